// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Receive side of the serial link. Deserializes start/data/stop frames
//   from a single-bit line that shares the receiver's clock domain.
//   Sampling uses a down-counter that reaches zero at mid-bit. The
//   received word is offered through a one-entry valid/ready holding
//   register. Overrun and framing errors are reported.
//
// Ports
//   clk     clock, rising edge
//   rst     synchronous active-high reset
//   sin     serial line, idles high
//   dout    holding register, the last accepted word
//   dvalid  dout holds an unconsumed word
//   dready  consumer accepts dout on an edge with dvalid && dready
//   ovr     sticky overrun, cleared by the next handshake
//   ferr    one-cycle pulse after a bad stop bit
//   busy    receiver is not idle
//
// State  | meaning
// IDLE   | line idle, waiting for a low level
// START  | counting to the middle of the start bit
// DATA   | sampling W data bits at mid-bit
// STOP   | counting to the middle of the stop bit
// BREAK  | bad stop bit seen, waiting for the line to go high

module serial_frame_receiver #(
  parameter int W            = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  output logic [W-1:0] dout,
  output logic         dvalid,
  input  logic         dready,
  output logic         ovr,
  output logic         ferr,
  output logic         busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [W-1:0]    sh_q, sh_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;
  logic            tick;
  logic            deliver;
  logic            hs;
  logic [W-1:0]    shift_in;

  // tick marks the mid-bit sampling edge of the current bit
  assign tick = (cnt_q == '0);
  assign hs   = dvalid_q && dready;

  assign shift_in = (MSB_FIRST != 0) ? ((sh_q << 1) | W'(sin))
                                     : ((sh_q >> 1) | (W'(sin) << (W - 1)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_d    = ovr_q;
    ferr_d   = 1'b0;
    deliver  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!sin) begin
          state_d = START;
          cnt_d   = CW'(H - 1);
        end
      end
      START: begin
        if (tick) begin
          if (sin) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = CW'(CLKS_PER_BIT - 1);
            bcnt_d  = BW'(W - 1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          sh_d  = shift_in;
          cnt_d = CW'(CLKS_PER_BIT - 1);
          if (bcnt_q == '0) begin
            state_d = STOP;
          end else begin
            bcnt_d = bcnt_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (sin) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BREAK: begin
        if (sin) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A delivery can reuse the slot when the old word is taken on the
    // same edge; otherwise a full slot drops the new word.
    if (deliver && (!dvalid_q || dready)) begin
      dout_d   = sh_q;
      dvalid_d = 1'b1;
    end else if (deliver) begin
      ovr_d = 1'b1;
    end else if (hs) begin
      dvalid_d = 1'b0;
    end
    if (hs) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      sh_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign ovr    = ovr_q;
  assign ferr   = ferr_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;
  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin;
  logic         dready0, dready1;
  logic [W-1:0] dout0, dout1;
  logic         dvalid0, dvalid1, ovr0, ovr1, ferr0, ferr1, busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           ferr_seen0 = 0;

  always #5 clk = ~clk;

  serial_frame_receiver #(.W(W), .CLKS_PER_BIT(N), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .sin(sin), .dout(dout0), .dvalid(dvalid0),
    .dready(dready0), .ovr(ovr0), .ferr(ferr0), .busy(busy0));

  serial_frame_receiver #(.W(W), .CLKS_PER_BIT(N), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .sin(sin), .dout(dout1), .dvalid(dvalid1),
    .dready(dready1), .ovr(ovr1), .ferr(ferr1), .busy(busy1));

  // record every consumed word and every ferr pulse
  always @(posedge clk) begin
    if (dvalid0 && dready0) q0.push_back(dout0);
    if (dvalid1 && dready1) q1.push_back(dout1);
    if (ferr0) ferr_seen0 <= ferr_seen0 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // called at posedge+1; first posedge after the call sees the start bit
  task automatic send_frame(input logic [W-1:0] d, input logic stop);
    sin = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int k = 0; k < W; k++) begin
      sin = d[k];
      repeat (N) @(posedge clk);
      #1;
    end
    sin = stop;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; sin = 1'b1; dready0 = 1'b1; dready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dout0 !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h expected 00", dout0); end
    n_cmp++; if (dvalid0 !== 1'b0) begin n_bad++; $display("FAIL reset_dvalid: got %b expected 0", dvalid0); end
    n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovr: got %b expected 0", ovr0); end
    n_cmp++; if (ferr0 !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", ferr0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    n_cmp++; if (dvalid1 !== 1'b0) begin n_bad++; $display("FAIL reset_dvalid_msb: got %b expected 0", dvalid1); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_lsb_frame;
    int bad_busy = 0, bad_dv = 0, bad_fe = 0, bad_ov = 0;
    int base = q0.size();
    logic [W-1:0] dv_word = 'x;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        for (int j = 1; j <= 45; j++) begin
          @(negedge clk);
          if (busy0 !== (j <= 38)) bad_busy++;
          if (dvalid0 !== (j == 39)) bad_dv++;
          if (j == 39) dv_word = dout0;
          if (ferr0 !== 1'b0) bad_fe++;
          if (ovr0 !== 1'b0) bad_ov++;
        end
      end
    join
    @(posedge clk);
    #1;
    n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL lsb_busy_window: %0d bad cycles, expected 0", bad_busy); end
    n_cmp++; if (bad_dv != 0) begin n_bad++; $display("FAIL lsb_dvalid_window: %0d bad cycles, expected 0", bad_dv); end
    n_cmp++; if (dv_word !== 8'hA5) begin n_bad++; $display("FAIL lsb_dout: got %h expected a5", dv_word); end
    n_cmp++; if (bad_fe != 0) begin n_bad++; $display("FAIL lsb_ferr: %0d bad cycles, expected 0", bad_fe); end
    n_cmp++; if (bad_ov != 0) begin n_bad++; $display("FAIL lsb_ovr: %0d bad cycles, expected 0", bad_ov); end
    n_cmp++; if (q0.size() != base + 1) begin n_bad++; $display("FAIL lsb_count: got %0d words expected 1", q0.size() - base); end
  endtask

  task automatic test_msb_first;
    int base = q1.size();
    logic [W-1:0] got;
    send_frame(8'h35, 1'b1);
    idle(4);
    got = (q1.size() > base) ? q1[base] : 'x;
    n_cmp++; if (got !== 8'hAC) begin n_bad++; $display("FAIL msb_dout: got %h expected ac", got); end
  endtask

  task automatic test_back_to_back;
    int b0 = q0.size();
    int b1 = q1.size();
    logic [W-1:0] g0a, g0b, g1a, g1b;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(4);
    g0a = (q0.size() > b0)     ? q0[b0]     : 'x;
    g0b = (q0.size() > b0 + 1) ? q0[b0 + 1] : 'x;
    g1a = (q1.size() > b1)     ? q1[b1]     : 'x;
    g1b = (q1.size() > b1 + 1) ? q1[b1 + 1] : 'x;
    n_cmp++; if (g0a !== 8'h12) begin n_bad++; $display("FAIL b2b_lsb_first: got %h expected 12", g0a); end
    n_cmp++; if (g0b !== 8'h34) begin n_bad++; $display("FAIL b2b_lsb_second: got %h expected 34", g0b); end
    n_cmp++; if (g1a !== 8'h48) begin n_bad++; $display("FAIL b2b_msb_first: got %h expected 48", g1a); end
    n_cmp++; if (g1b !== 8'h2C) begin n_bad++; $display("FAIL b2b_msb_second: got %h expected 2c", g1b); end
  endtask

  task automatic test_false_start;
    int bad_busy = 0, bad_dv = 0, bad_fe = 0;
    fork
      begin
        sin = 1'b0;
        @(posedge clk);
        #1;
        sin = 1'b1;
      end
      begin
        @(posedge clk);
        for (int j = 1; j <= 10; j++) begin
          @(negedge clk);
          if (busy0 !== (j <= 2)) bad_busy++;
          if (dvalid0 !== 1'b0) bad_dv++;
          if (ferr0 !== 1'b0) bad_fe++;
        end
      end
    join
    @(posedge clk);
    #1;
    n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL false_start_busy: %0d bad cycles, expected 0", bad_busy); end
    n_cmp++; if (bad_dv != 0) begin n_bad++; $display("FAIL false_start_dvalid: %0d bad cycles, expected 0", bad_dv); end
    n_cmp++; if (bad_fe != 0) begin n_bad++; $display("FAIL false_start_ferr: %0d bad cycles, expected 0", bad_fe); end
  endtask

  task automatic test_framing_error;
    int bad_busy = 0, bad_dv = 0, bad_fe = 0;
    int base;
    logic [W-1:0] got;
    fork
      begin
        send_frame(8'h5A, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        sin = 1'b1;
      end
      begin
        @(posedge clk);
        for (int j = 1; j <= 65; j++) begin
          @(negedge clk);
          if (busy0 !== (j <= 60)) bad_busy++;
          if (ferr0 !== (j == 39)) bad_fe++;
          if (dvalid0 !== 1'b0) bad_dv++;
        end
      end
    join
    @(posedge clk);
    #1;
    n_cmp++; if (bad_fe != 0) begin n_bad++; $display("FAIL ferr_pulse: %0d bad cycles, expected 0", bad_fe); end
    n_cmp++; if (bad_dv != 0) begin n_bad++; $display("FAIL ferr_dvalid: %0d bad cycles, expected 0", bad_dv); end
    n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL ferr_break_busy: %0d bad cycles, expected 0", bad_busy); end
    base = q0.size();
    send_frame(8'h5A, 1'b1);
    idle(4);
    got = (q0.size() > base) ? q0[base] : 'x;
    n_cmp++; if (got !== 8'h5A) begin n_bad++; $display("FAIL ferr_recover_dout: got %h expected 5a", got); end
  endtask

  task automatic test_overrun;
    dready0 = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(3);
    n_cmp++; if (dout0 !== 8'h11) begin n_bad++; $display("FAIL ovr_dout_held: got %h expected 11", dout0); end
    n_cmp++; if (dvalid0 !== 1'b1) begin n_bad++; $display("FAIL ovr_dvalid_held: got %b expected 1", dvalid0); end
    n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b expected 1", ovr0); end
    dready0 = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (dvalid0 !== 1'b0) begin n_bad++; $display("FAIL ovr_hs_dvalid: got %b expected 0", dvalid0); end
    n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL ovr_hs_clear: got %b expected 0", ovr0); end
    n_cmp++; if (dout0 !== 8'h11) begin n_bad++; $display("FAIL ovr_hs_dout: got %h expected 11", dout0); end
    idle(2);
  endtask

  task automatic test_reset_mid_frame;
    int fe_base = ferr_seen0;
    int base = q0.size();
    logic [W-1:0] got;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk);
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (dout0 !== 8'h00) begin n_bad++; $display("FAIL midrst_dout: got %h expected 00", dout0); end
        n_cmp++; if (dvalid0 !== 1'b0) begin n_bad++; $display("FAIL midrst_dvalid: got %b expected 0", dvalid0); end
        n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL midrst_ovr: got %b expected 0", ovr0); end
        n_cmp++; if (ferr0 !== 1'b0) begin n_bad++; $display("FAIL midrst_ferr: got %b expected 0", ferr0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy0); end
        rst = 1'b0;
      end
    join
    idle(4);
    send_frame(8'h3C, 1'b1);
    idle(4);
    got = (q0.size() > base) ? q0[base] : 'x;
    n_cmp++; if (got !== 8'h3C) begin n_bad++; $display("FAIL midrst_next_dout: got %h expected 3c", got); end
    n_cmp++; if (q0.size() != base + 1) begin n_bad++; $display("FAIL midrst_word_count: got %0d expected 1", q0.size() - base); end
    n_cmp++; if (ferr_seen0 != fe_base) begin n_bad++; $display("FAIL midrst_no_ferr: got %0d pulses expected 0", ferr_seen0 - fe_base); end
  endtask

  initial begin
    test_reset();
    test_lsb_frame();
    test_msb_first();
    test_back_to_back();
    idle(3);
    test_false_start();
    idle(3);
    test_framing_error();
    idle(3);
    test_overrun();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
